// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Iteration counter must be able to hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True when DIGITS decimal digits can represent 2^WIDTH-1.
    function automatic bit digits_fit(input int width, input int digits);
        longint unsigned p10;
        longint unsigned lim;
        p10 = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        lim = 1;
        lim = (lim << width) - 1;
        return p10 > lim;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Max input is 9 in practice (12 worst case), so no carry-out is needed.
    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter with start/done handshake; one bit per clock.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
        $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t              state;
    logic [WIDTH-1:0]    bin_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    // Adjust first, then shift the binary MSB into the scratch LSB.
    assign scratch_nxt = {adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
    assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bin_reg <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= scratch_nxt;
                    bin_reg <= bin_reg << 1;
                    if (last_iter) begin
                        // Final iteration's result goes straight to the output.
                        bcd   <= scratch_nxt;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
